// File: rtl/espic_pkg.sv
// Shared ESPIC definitions: controller opcodes, IRQ source ids, issuer states.
package espic_pkg;

    localparam logic [15:0] OP_IDLE         = 16'h0000;
    localparam logic [15:0] OP_SETPRIO_BASE = 16'h2F10;
    localparam logic [15:0] OP_SETPRIO_MASK = 16'h3FF0;
    localparam logic [15:0] OP_IRQ2_N0      = 16'h3F11;
    localparam logic [15:0] OP_IRQ2_N1      = 16'h3F12;

    typedef enum logic [1:0] {
        IRQ_ID_TICK  = 2'd0,
        IRQ_ID_MUTEX = 2'd1,
        IRQ_ID_MEM   = 2'd2
    } irq_id_e;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_DRIVE = 2'd1,
        ISS_GAP   = 2'd2
    } iss_state_e;

    // Builds the controller opcode for a CPU command.
    function automatic logic [15:0] encode_op(input logic kind,
                                              input logic [2:0] prio,
                                              input logic node);
        logic [15:0] op;
        if (kind) begin
            op = node ? OP_IRQ2_N1 : OP_IRQ2_N0;
        end else begin
            op = (OP_SETPRIO_BASE & OP_SETPRIO_MASK) | {13'b0, prio};
        end
        return op;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/node_irq_agent.sv
// Node-side ESPIC endpoint: latches IRQ edges for the CPU and issues opcodes.
module node_irq_agent
    import espic_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int OP_HOLD = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_IRQ0,
    input  logic [1:0]  in_mutex_IRQ1,
    input  logic        in_IRQ2,
    output logic        irq_valid,
    output logic [1:0]  irq_id,
    output logic        irq_overrun,
    input  logic        irq_ack,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_kind,
    input  logic [3:0]  cmd_arg,
    output logic [15:0] out_op
);

    localparam logic [7:0] HOLD_LOAD = 8'(OP_HOLD - 1);

    logic [2:0]  rise;
    logic [2:0]  pending;
    logic [2:0]  overrun;
    logic [2:0]  ack_hit;
    irq_id_e     sel_id;

    iss_state_e  state;
    iss_state_e  state_next;
    logic [7:0]  count;
    logic [7:0]  count_next;
    logic [15:0] op_reg;
    logic [15:0] op_next;

    logic        unused_inputs;
    assign unused_inputs = cmd_arg[3] ^ (^in_mutex_IRQ1);

    irq_sync_edge u_sync_irq0 (.CLK(CLK), .RST(RST), .async_in(in_IRQ0),                 .rise(rise[0]));
    irq_sync_edge u_sync_irq1 (.CLK(CLK), .RST(RST), .async_in(in_mutex_IRQ1[NODE_ID]),  .rise(rise[1]));
    irq_sync_edge u_sync_irq2 (.CLK(CLK), .RST(RST), .async_in(in_IRQ2),                 .rise(rise[2]));

    // Acknowledge only targets the currently presented source.
    always_comb begin
        ack_hit = 3'b000;
        if (irq_ack && irq_valid) begin
            ack_hit = 3'b001 << irq_id;
        end
    end

    // Pending/overrun bookkeeping; a fresh edge beats a same-cycle ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= 3'b000;
            overrun <= 3'b000;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (rise[s]) begin
                    pending[s] <= 1'b1;
                    overrun[s] <= ack_hit[s] ? 1'b0 : (overrun[s] | pending[s]);
                end else if (ack_hit[s]) begin
                    pending[s] <= 1'b0;
                    overrun[s] <= 1'b0;
                end
            end
        end
    end

    // Fixed priority select: IRQ2 over IRQ1 over IRQ0.
    always_comb begin
        sel_id = IRQ_ID_TICK;
        if (pending[2]) begin
            sel_id = IRQ_ID_MEM;
        end else if (pending[1]) begin
            sel_id = IRQ_ID_MUTEX;
        end
    end

    assign irq_valid   = |pending;
    assign irq_id      = sel_id;
    assign irq_overrun = pending[irq_id] & overrun[irq_id];

    // Issuer state, hold counter and latched opcode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ISS_IDLE;
            count  <= 8'd0;
            op_reg <= OP_IDLE;
        end else begin
            state  <= state_next;
            count  <= count_next;
            op_reg <= op_next;
        end
    end

    // Issuer next state: accept, hold for OP_HOLD cycles, then one idle gap.
    always_comb begin
        state_next = state;
        count_next = count;
        op_next    = op_reg;
        case (state)
            ISS_IDLE: begin
                if (cmd_valid) begin
                    state_next = ISS_DRIVE;
                    count_next = HOLD_LOAD;
                    op_next    = encode_op(cmd_kind, cmd_arg[2:0], cmd_arg[0]);
                end
            end
            ISS_DRIVE: begin
                if (count == 8'd0) begin
                    state_next = ISS_GAP;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            ISS_GAP: begin
                state_next = ISS_IDLE;
            end
            default: begin
                state_next = ISS_IDLE;
            end
        endcase
    end

    // Issuer outputs; ready is held low while reset is asserted.
    always_comb begin
        cmd_ready = (state == ISS_IDLE) && !RST;
        out_op    = (state == ISS_DRIVE) ? op_reg : OP_IDLE;
    end

endmodule

// File: tb/tb_node_irq_agent.sv
// Directed self-checking bench for node_irq_agent (NODE_ID=1, OP_HOLD=4).
module tb_node_irq_agent;

    logic        CLK;
    logic        RST;
    logic        in_IRQ0;
    logic [1:0]  in_mutex_IRQ1;
    logic        in_IRQ2;
    logic        irq_valid;
    logic [1:0]  irq_id;
    logic        irq_overrun;
    logic        irq_ack;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_kind;
    logic [3:0]  cmd_arg;
    logic [15:0] out_op;

    int checks;
    int fails;

    node_irq_agent #(.NODE_ID(1), .OP_HOLD(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_IRQ0(in_IRQ0),
        .in_mutex_IRQ1(in_mutex_IRQ1),
        .in_IRQ2(in_IRQ2),
        .irq_valid(irq_valid),
        .irq_id(irq_id),
        .irq_overrun(irq_overrun),
        .irq_ack(irq_ack),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind),
        .cmd_arg(cmd_arg),
        .out_op(out_op)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advances n rising edges and lands 1 unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        in_IRQ0 = 1'b0;
        in_mutex_IRQ1 = 2'b00;
        in_IRQ2 = 1'b0;
        irq_ack = 1'b0;
        cmd_valid = 1'b0;
        cmd_kind = 1'b0;
        cmd_arg = 4'h0;
        step(1);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", irq_valid); end
        checks++;
        if (irq_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_id: got %0d expected 0", irq_id); end
        checks++;
        if (irq_overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b expected 0", irq_overrun); end
        checks++;
        if (cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++;
        if (out_op !== 16'h0000) begin fails++; $display("[TB] FAIL reset_op: got %h expected 0000", out_op); end
        step(1);
        RST = 1'b0;
        step(1);
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL ready_after_reset: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_irq2_pulse;
        in_IRQ2 = 1'b1;
        step(2);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL irq2_early: got %b expected 0", irq_valid); end
        step(1);
        checks++;
        if (irq_valid !== 1'b1) begin fails++; $display("[TB] FAIL irq2_valid: got %b expected 1", irq_valid); end
        checks++;
        if (irq_id !== 2'd2) begin fails++; $display("[TB] FAIL irq2_id: got %0d expected 2", irq_id); end
        checks++;
        if (irq_overrun !== 1'b0) begin fails++; $display("[TB] FAIL irq2_overrun: got %b expected 0", irq_overrun); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL irq2_acked: got %b expected 0", irq_valid); end
        step(990);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL irq2_held_no_retrigger: got %b expected 0", irq_valid); end
        in_IRQ2 = 1'b0;
        step(5);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL irq2_fall_no_event: got %b expected 0", irq_valid); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_ack_ignored: got %b expected 0", irq_valid); end
    endtask

    task automatic test_simultaneous;
        in_IRQ0 = 1'b1;
        in_IRQ2 = 1'b1;
        step(3);
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin fails++; $display("[TB] FAIL simul_first: got valid=%b id=%0d expected valid=1 id=2", irq_valid, irq_id); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin fails++; $display("[TB] FAIL simul_second: got valid=%b id=%0d expected valid=1 id=0", irq_valid, irq_id); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL simul_drained: got %b expected 0", irq_valid); end
        in_IRQ0 = 1'b0;
        in_IRQ2 = 1'b0;
        step(3);
    endtask

    task automatic test_mutex;
        in_mutex_IRQ1 = 2'b01;
        step(4);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL mutex_other_bit: got %b expected 0", irq_valid); end
        in_mutex_IRQ1 = 2'b10;
        step(3);
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd1) begin fails++; $display("[TB] FAIL mutex_own_bit: got valid=%b id=%0d expected valid=1 id=1", irq_valid, irq_id); end
        checks++;
        if (irq_overrun !== 1'b0) begin fails++; $display("[TB] FAIL mutex_no_overrun: got %b expected 0", irq_overrun); end
        in_mutex_IRQ1 = 2'b00;
        step(3);
        in_mutex_IRQ1 = 2'b10;
        step(3);
        checks++;
        if (irq_overrun !== 1'b1 || irq_id !== 2'd1) begin fails++; $display("[TB] FAIL mutex_overrun: got ovr=%b id=%0d expected ovr=1 id=1", irq_overrun, irq_id); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0 || irq_overrun !== 1'b0) begin fails++; $display("[TB] FAIL mutex_ack_clear: got valid=%b ovr=%b expected 0 0", irq_valid, irq_overrun); end
        in_mutex_IRQ1 = 2'b00;
        step(3);
    endtask

    task automatic test_edge_beats_ack;
        in_IRQ0 = 1'b1;
        step(3);
        in_IRQ0 = 1'b0;
        step(3);
        in_IRQ0 = 1'b1;
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0 || irq_overrun !== 1'b0) begin fails++; $display("[TB] FAIL edge_beats_ack: got valid=%b id=%0d ovr=%b expected 1 0 0", irq_valid, irq_id, irq_overrun); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL edge_beats_ack_clear: got %b expected 0", irq_valid); end
        in_IRQ0 = 1'b0;
        step(3);
    endtask

    task automatic test_setprio;
        cmd_valid = 1'b1;
        cmd_kind = 1'b0;
        cmd_arg = 4'hD;
        step(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_op !== 16'h2F15 || cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL setprio_drive[%0d]: got op=%h rdy=%b expected 2f15 0", i, out_op, cmd_ready); end
            step(1);
        end
        checks++;
        if (out_op !== 16'h0000 || cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL setprio_gap: got op=%h rdy=%b expected 0000 0", out_op, cmd_ready); end
        step(1);
        checks++;
        if (out_op !== 16'h0000 || cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL setprio_idle: got op=%h rdy=%b expected 0000 1", out_op, cmd_ready); end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1;
        cmd_kind = 1'b1;
        cmd_arg = 4'h0;
        step(1);
        cmd_arg = 4'h1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_op !== 16'h3F11) begin fails++; $display("[TB] FAIL b2b_first[%0d]: got %h expected 3f11", i, out_op); end
            step(1);
        end
        checks++;
        if (out_op !== 16'h0000 || cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_gap: got op=%h rdy=%b expected 0000 0", out_op, cmd_ready); end
        step(1);
        checks++;
        if (out_op !== 16'h0000 || cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept: got op=%h rdy=%b expected 0000 1", out_op, cmd_ready); end
        step(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_op !== 16'h3F12) begin fails++; $display("[TB] FAIL b2b_second[%0d]: got %h expected 3f12", i, out_op); end
            step(1);
        end
        checks++;
        if (out_op !== 16'h0000) begin fails++; $display("[TB] FAIL b2b_end: got %h expected 0000", out_op); end
        step(2);
    endtask

    task automatic test_reset_during_drive;
        in_IRQ0 = 1'b1;
        step(3);
        checks++;
        if (irq_valid !== 1'b1) begin fails++; $display("[TB] FAIL rdd_pending: got %b expected 1", irq_valid); end
        cmd_valid = 1'b1;
        cmd_kind = 1'b0;
        cmd_arg = 4'h1;
        step(1);
        cmd_valid = 1'b0;
        step(1);
        checks++;
        if (out_op !== 16'h2F11) begin fails++; $display("[TB] FAIL rdd_drive2: got %h expected 2f11", out_op); end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (out_op !== 16'h0000 || irq_valid !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL rdd_async: got op=%h valid=%b rdy=%b expected 0000 0 0", out_op, irq_valid, cmd_ready); end
        step(2);
        RST = 1'b0;
        step(2);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL rdd_early: got %b expected 0", irq_valid); end
        step(1);
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin fails++; $display("[TB] FAIL rdd_held_event: got valid=%b id=%0d expected 1 0", irq_valid, irq_id); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(20);
        checks++;
        if (irq_valid !== 1'b0) begin fails++; $display("[TB] FAIL rdd_single_event: got %b expected 0", irq_valid); end
        checks++;
        if (out_op !== 16'h0000 || cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL rdd_issuer_idle: got op=%h rdy=%b expected 0000 1", out_op, cmd_ready); end
        in_IRQ0 = 1'b0;
    endtask

    // Runs each scenario in order, then reports totals.
    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_irq2_pulse();
        test_simultaneous();
        test_mutex();
        test_edge_beats_ack();
        test_setprio();
        test_back_to_back();
        test_reset_during_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
